req_grant_responder: RTL



---
 rtl/req_grant_pkg.sv | 11 +
 rtl/req_grant_responder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/req_grant_pkg.sv
// Shared types and widths for the two-requester grant responder.
package req_grant_pkg;

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, GAP} rg_state_t;

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic {ReqId1 = 1'b0, ReqId2 = 1'b1} req_id_t;

endpackage

// File: rtl/req_grant_responder.sv
// Round-robin responder for the req1/req2 handshake: one-hot registered grants with a bounded
// hold time and an enforced idle gap between successive grants.
module req_grant_responder
  import req_grant_pkg::*;
#(
  parameter int unsigned HOLD_MAX   = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic              req2,
  output logic              gnt1,
  output logic              gnt2,
  output logic              busy,
  output logic              timeout,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(HOLD_MAX);
  localparam logic [GAP_W-1:0]  GapMax  = GAP_W'(GAP_CYCLES);

  rg_state_t         state_q, state_d;
  req_id_t           last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              gnt1_q, gnt1_d;
  logic              gnt2_q, gnt2_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              own_req;
  logic              req_unknown;

  assign own_req     = (state_q == GRANT1) ? req1 : req2;
  assign req_unknown = $isunknown({req1, req2});

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = '0;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_d = '0;
        // On a tie the requester that did not win last time is served.
        if (req1 && (!req2 || last_q == ReqId2)) begin
          state_d = GRANT1;
          last_d  = ReqId1;
          hold_d  = HOLD_W'(1);
        end else if (req2) begin
          state_d = GRANT2;
          last_d  = ReqId2;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT1, GRANT2: begin
        if (!own_req) begin
          state_d = GAP;
          gap_d   = GAP_W'(1);
        end else if (hold_q == HoldMax) begin
          state_d   = GAP;
          gap_d     = GAP_W'(1);
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GapMax) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt1_d = (state_d == GRANT1);
    gnt2_d = (state_d == GRANT2);
    busy_d = gnt1_d | gnt2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= ReqId2;
      hold_q    <= '0;
      gap_q     <= '0;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      assert (!req_unknown) else $error("req1/req2 unknown, state held");
      // An unknown request freezes every register rather than guessing a winner.
      if (!req_unknown) begin
        state_q   <= state_d;
        last_q    <= last_d;
        hold_q    <= hold_d;
        gap_q     <= gap_d;
        gnt1_q    <= gnt1_d;
        gnt2_q    <= gnt2_d;
        busy_q    <= busy_d;
        timeout_q <= timeout_d;
        if (state_q == IDLE && (state_d == GRANT1 || state_d == GRANT2)) begin
          assert (req1 || req2) else $error("grant entered with no request");
        end
      end
      assert (!(gnt1_q && gnt2_q)) else $error("grants not one-hot");
      assert (busy_q == (gnt1_q | gnt2_q)) else $error("busy inconsistent with grants");
    end
  end

  assign gnt1     = gnt1_q;
  assign gnt2     = gnt2_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign hold_cnt = hold_q;

endmodule
